// File: rtl/key192_sched.sv
// AES-192 key-expansion sequencer: produces w[0..51] one word per cycle and
// streams the 13 packed 128-bit round keys over a valid/ready handshake.
module key192_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] sel);
    logic [7:0] rc;
    unique case (sel)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  state_e             state_q, state_d;
  logic [5:0]         widx_q, widx_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [5:0][31:0]   win_q, win_d;   // win[0] = w[widx-6], win[5] = w[widx-1]
  logic [2:0][31:0]   acc_q, acc_d;
  logic               rk_valid_q, rk_valid_d;
  logic [127:0]       rk_data_q, rk_data_d;
  logic [3:0]         rk_idx_q, rk_idx_d;
  logic               done_q, done_d;

  logic [31:0] word, rot, sub;
  logic [3:0]  rcon_sel;
  logic        first_of_group, stall, gen;

  always_comb begin
    rot            = {win_q[5][23:0], win_q[5][31:24]};
    sub            = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    rcon_sel       = 4'(widx_q / 6'd6);
    first_of_group = (widx_q % 6'd6) == 6'd0;
    if (widx_q < 6'd6) begin
      word = win_q[widx_q[2:0]];
    end else if (first_of_group) begin
      word = win_q[0] ^ sub ^ rcon(rcon_sel);
    end else begin
      word = win_q[0] ^ win_q[5];
    end
  end

  // Only a key-completing word waits on a full output register.
  assign stall = (cnt_q == 2'd3) && rk_valid_q && !rk_ready;
  assign gen   = (state_q == StRun) && !stall;

  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    acc_d      = acc_q;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    done_d     = 1'b0;

    if (rk_valid_q && rk_ready) rk_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int i = 0; i < 6; i++) win_d[i] = key[191 - 32*i -: 32];
          widx_d  = 6'd0;
          cnt_d   = 2'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (gen) begin
          widx_d = widx_q + 6'd1;
          if (widx_q >= 6'd6) win_d = {word, win_q[5:1]};
          if (cnt_q == 2'd3) begin
            rk_data_d  = {acc_q[0], acc_q[1], acc_q[2], word};
            rk_idx_d   = widx_q[5:2];
            rk_valid_d = 1'b1;
            cnt_d      = 2'd0;
          end else begin
            acc_d[cnt_q] = word;
            cnt_d        = cnt_q + 2'd1;
          end
          if (widx_q == 6'd51) state_d = StDrain;
        end
      end
      StDrain: begin
        if (rk_valid_q && rk_ready) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      widx_q     <= '0;
      cnt_q      <= '0;
      win_q      <= '0;
      acc_q      <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key192_sched.sv
// Scoreboard bench for key192_sched: reference AES-192 expansion fills a queue,
// a negedge monitor pops and compares every accepted round key.
module tb_key192_sched;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [191:0] key;
  logic         busy, rk_valid, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  key192_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } rk_t;

  localparam logic [191:0] FipsKey = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  rk_t         exp_q[$];
  logic [7:0]  sbox_t[256];
  int          ready_mode = 0;   // 0: always, 1: random ~30%, 3: hold key hold_idx
  int          hold_idx = 15;
  int          t_start = 0;
  bit          timing_en = 0;
  bit          kat_en = 0;
  bit          kat_has[13];
  logic [127:0] kat_val[13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (prod[k]) prod = prod ^ (15'h11b << (k - 8));
    return prod[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  task automatic push_expected(input logic [191:0] k);
    logic [31:0] w[52];
    logic [31:0] t;
    rk_t         e;
    for (int i = 0; i < 6; i++) w[i] = k[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ (32'd1 << (23 + i / 6));
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) begin
      e.idx  = 4'(r);
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    rk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       rk_ready = 1'b1;
        1:       rk_ready = ($urandom_range(0, 99) < 30);
        default: rk_ready = !(rk_valid && (int'(rk_idx) == hold_idx));
      endcase
    end
  end

  // Monitor: scoreboard pops, output stability under backpressure, done timing.
  initial begin
    bit          stall_prev, done_exp;
    logic [127:0] prev_data;
    logic [3:0]  prev_idx;
    rk_t         e;
    stall_prev = 0;
    done_exp   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
        done_exp   = 0;
      end else begin
        chk("done", 128'(done), 128'(done_exp));
        done_exp = 0;
        if (stall_prev) begin
          chk("hold_valid", 128'(rk_valid), 128'(1));
          chk("hold_data", rk_data, prev_data);
          chk("hold_idx", 128'(rk_idx), 128'(prev_idx));
        end
        if (rk_valid && rk_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_key_idx", 128'(rk_idx), 128'hffff);
          end else begin
            e = exp_q.pop_front();
            chk("rk_idx", 128'(rk_idx), 128'(e.idx));
            chk("rk_data", rk_data, e.data);
            if (kat_en && kat_has[e.idx]) chk("kat", rk_data, kat_val[e.idx]);
            if (timing_en) chk("latency", 128'(cyc - t_start), 128'(4 + 4 * int'(e.idx)));
            if (e.idx == 4'd12) done_exp = 1;
          end
        end
        stall_prev = rk_valid && !rk_ready;
        prev_data  = rk_data;
        prev_idx   = rk_idx;
      end
    end
  end

  task automatic issue(input logic [191:0] k, input bit push);
    @(posedge clk);
    #1;
    key   = k;
    start = 1'b1;
    if (push) push_expected(k);
    @(posedge clk);
    #1;
    start   = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(name, 128'(seen), 128'(1));
    if (seen) chk("busy_at_done", 128'(busy), 128'(0));
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic wait_key(input string name, input int idx, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rk_valid && int'(rk_idx) == idx) seen = 1;
    end
    chk(name, 128'(seen), 128'(1));
  endtask

  task automatic clear_kat();
    kat_en = 0;
    for (int i = 0; i < 13; i++) kat_has[i] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    clear_kat();
    build_sbox();
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_data", rk_data, 128'(0));
    chk("rst_idx", 128'(rk_idx), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Known-answer vector with full-rate consumer and timing checks.
    kat_val[0]  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    kat_val[1]  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    kat_val[12] = 128'he98ba06f448c773c8ecc720401002202;
    kat_has[0] = 1; kat_has[1] = 1; kat_has[12] = 1;
    kat_en     = 1;
    ready_mode = 0;
    timing_en  = 1;
    issue(FipsKey, 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("early_valid", 128'(rk_valid), 128'(0));
      chk("busy_run", 128'(busy), 128'(1));
    end
    wait_done("done_fips", 100);
    timing_en = 0;

    // Same key under random backpressure, with an ignored mid-run start.
    ready_mode = 1;
    issue(FipsKey, 1);
    repeat (10) @(posedge clk);
    #1;
    key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("done_fips_rand", 400);
    clear_kat();

    for (int n = 0; n < 3; n++) begin
      issue({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1);
      wait_done("done_rand_key", 400);
    end

    // Reset while key 6 is stalled.
    ready_mode = 3;
    hold_idx   = 6;
    issue({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1);
    wait_key("reach_key6", 6, 200);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_valid", 128'(rk_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    @(posedge clk);
    #1;
    rst        = 1'b0;
    hold_idx   = 15;
    ready_mode = 0;
    kat_val[0] = 128'h0;
    kat_val[1] = 128'h00000000000000006263636362636363;
    kat_has[0] = 1; kat_has[1] = 1;
    kat_en     = 1;
    issue(192'h0, 1);
    wait_done("done_zero", 100);
    clear_kat();

    // Key 12 held in DRAIN for 20 cycles.
    ready_mode = 3;
    hold_idx   = 12;
    issue(FipsKey, 1);
    wait_key("reach_key12", 12, 200);
    for (int j = 0; j < 20; j++) begin
      chk("drain_busy", 128'(busy), 128'(1));
      chk("drain_done", 128'(done), 128'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    hold_idx = 15;
    wait_done("done_drain", 10);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key192_sched.md
Name: key192_sched

Overview:
- Iterative AES-192 key-expansion sequencer for the encrypt/key192 path.
- Latches a 192-bit cipher key on a start handshake, then generates w[0..51] at one 32-bit word per cycle.
- Packs the words into 13 128-bit round keys and streams them out on a valid/ready interface.
- Drives the rcon table (4-bit sel, 32-bit word) and four byte S-box lookups internally, replacing the fully unrolled combinational expansion.

Parameters:
- none; Nk=6, 52 words and 13 round keys are fixed.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request expansion; accepted only in IDLE.
- key  input  192  cipher key; key[191:160]=w0 … key[31:0]=w5; sampled in the start-accept cycle.
- busy  output  1  high in RUN and DRAIN.
- rk_valid  output  1  rk_data/rk_idx hold a round key.
- rk_ready  input  1  consumer accepts the key when rk_valid && rk_ready.
- rk_data  output  128  round key; word order {w[4r],w[4r+1],w[4r+2],w[4r+3]}, MSW first.
- rk_idx  output  4  round index r, 0..12.
- done  output  1  one-cycle pulse after round key 12 is accepted.

Behaviour:
- Reset: state=IDLE, widx=0, assembler count=0, window=0. All outputs 0: busy, rk_valid, rk_data, rk_idx, done.
- Reset mid-operation aborts immediately. No partial key is output afterwards.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches key into the 6-word window and clears widx and the assembler count; next state RUN.
  - start is ignored in RUN and DRAIN, and key is not resampled.
- Word generation (RUN): one word per cycle when not stalled.
  - widx<6: word = window[widx] (the key words).
  - widx≥6 and widx%6==0: word = w[widx-6] ^ SubWord(RotWord(w[widx-1])) ^ rcon(sel=widx/6). sel ranges 1..8.
  - Otherwise: word = w[widx-6] ^ w[widx-1].
  - For widx≥6, the window shifts in the new word.
  - widx increments by 1 per generated word.
- Assembler: a 4-word accumulator with count 0..3.
  - When the 4th word arrives: rk_data ← the 4 words, rk_idx ← widx/4, rk_valid←1 on the next edge, count→0.
- Stall: a generation cycle is blocked only if it would complete a key while rk_valid && !rk_ready. The output register holds; there is no data loss and no overwrite.
- Handshake:
  - rk_valid stays high with rk_data and rk_idx stable until accepted.
  - Acceptance and loading of a new key in the same cycle is allowed, giving back-to-back keys.
- RUN→DRAIN after w[51] is generated (widx reaches 52).
- DRAIN: waits for acceptance of key 12. On that accept: done=1 for one cycle, rk_valid→0, next state IDLE.
- Latency: start accepted at edge T; w0 at T+1; key 0 valid after edge T+4.
  - With rk_ready held high, key r is valid after edge T+4+4r.
  - done pulses in the cycle after key 12 is accepted (edge T+53).
- Boundary: widx wraps to 0 only on a new start. Words beyond w51 are never generated.

Test Plan:
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, rk_ready=1 -> rk0=8e73b0f7da0e6452c810f32b809079e5; rk1=62f8ead2522c6b7bfe0c91f72402f5a5; rk12=e98ba06f448c773c8ecc720401002202; rk_idx 0..12 in order; done pulses once.
- Same key, rk_ready random ~30% duty -> identical 13-key sequence; rk_data/rk_idx stable while rk_valid && !rk_ready; no key skipped or duplicated.
- Timing with rk_ready=1 -> first rk_valid 4 cycles after start accept; keys spaced 4 cycles apart; busy high from T+1 until IDLE return.
- start pulsed mid-RUN with a different key -> ignored; output still matches the original key.
- rst asserted during key 6 stall -> next cycle rk_valid=0, busy=0, done=0. New start with all-zero key -> rk0=0, rk1=000000000000000062636363 62636363.
- Key 12 held un-accepted 20 cycles in DRAIN -> busy=1 and done=0 throughout; done pulses in the cycle after rk_ready rises.
